// File: rtl/shift_univ.sv
// rtl/shift_univ.sv - universal shift register with direct ops and counted burst mode
module shift_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       op_i,
  input  logic             in_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [WIDTH-1:0] out_o,
  output logic             shout_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_SHR   = 3'd1;
  localparam logic [2:0] OP_SHL   = 3'd2;
  localparam logic [2:0] OP_ROR   = 3'd3;
  localparam logic [2:0] OP_ROL   = 3'd4;
  localparam logic [2:0] OP_ASR   = 3'd5;
  localparam logic [2:0] OP_LOAD  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             shout_q, shout_d;
  logic             done_q, done_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       exec_op;
  logic             op_is_shift;

  assign op_is_shift = (op_i >= OP_SHR) && (op_i <= OP_ASR);

  // Control: decides which op (if any) the datapath executes this cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    exec_op = OP_HOLD;
    case (state_q)
      S_IDLE: begin
        if (start_i && op_is_shift) begin
          if (count_i != '0) begin
            state_d = S_RUN;
            op_d    = op_i;
            cnt_d   = count_i;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          exec_op = op_i;
        end
      end
      S_RUN: begin
        exec_op = op_q;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    r_d     = r_q;
    shout_d = shout_q;
    case (exec_op)
      OP_SHR: begin
        r_d     = {in_i, r_q[WIDTH-1:1]};
        shout_d = r_q[0];
      end
      OP_SHL: begin
        r_d     = {r_q[WIDTH-2:0], in_i};
        shout_d = r_q[WIDTH-1];
      end
      OP_ROR: begin
        r_d     = {r_q[0], r_q[WIDTH-1:1]};
        shout_d = r_q[0];
      end
      OP_ROL: begin
        r_d     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        shout_d = r_q[WIDTH-1];
      end
      OP_ASR: begin
        r_d     = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        shout_d = r_q[0];
      end
      OP_LOAD: begin
        r_d     = load_data_i;
        shout_d = 1'b0;
      end
      OP_CLEAR: begin
        r_d     = '0;
        shout_d = 1'b0;
      end
      default: begin
        r_d     = r_q;
        shout_d = shout_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      shout_q <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      shout_q <= shout_d;
      done_q  <= done_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_o   = r_q;
  assign shout_o = shout_q;
  assign busy_o  = (state_q == S_RUN);
  assign done_o  = done_q;

endmodule

// File: tb/tb_shift_univ.sv
// tb/tb_shift_univ.sv - randomized self-checking bench for shift_univ (8- and 16-bit instances)
module tb_shift_univ;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dsel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        din = 1'b0;
  logic [15:0] ld = 16'h0;
  logic        start = 1'b0;
  logic [4:0]  count = 5'd0;

  logic [7:0]  out8;
  logic        sh8, busy8, done8;
  logic [15:0] out16;
  logic        sh16, busy16, done16;

  logic [2:0]  op8, op16;
  logic [15:0] out_s;
  logic        sh_s, busy_s, done_s;

  logic [15:0] m_r = 16'h0;
  logic        m_sh = 1'b0;
  int          n_pass = 0;
  int          n_chk = 0;

  always #5 clk = ~clk;

  assign op8    = dsel ? 3'd0 : op;
  assign op16   = dsel ? op : 3'd0;
  assign out_s  = dsel ? out16 : {8'h00, out8};
  assign sh_s   = dsel ? sh16 : sh8;
  assign busy_s = dsel ? busy16 : busy8;
  assign done_s = dsel ? done16 : done8;

  shift_univ #(.WIDTH(8), .CNT_W(4)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op8), .in_i(din), .load_data_i(ld[7:0]),
    .start_i(start & ~dsel), .count_i(count[3:0]),
    .out_o(out8), .shout_o(sh8), .busy_o(busy8), .done_o(done8)
  );

  shift_univ #(.WIDTH(16), .CNT_W(5)) u16 (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op16), .in_i(din), .load_data_i(ld),
    .start_i(start & dsel), .count_i(count),
    .out_o(out16), .shout_o(sh16), .busy_o(busy16), .done_o(done16)
  );

  // Arithmetic reference: returns {shout, register} after one op on a w-bit register.
  function automatic logic [16:0] ref_step(input int w, input logic [2:0] o, input logic [15:0] r,
                                           input logic sh, input logic d, input logic [15:0] l);
    int unsigned ri, mask, msb, rn, shn;
    ri = r; mask = (32'd1 << w) - 1; msb = (ri >> (w - 1)) & 1; rn = ri; shn = sh;
    case (o)
      3'd1: begin rn = (ri >> 1) | (int'(d) << (w - 1)); shn = ri & 1; end
      3'd2: begin rn = ((ri << 1) | int'(d)) & mask; shn = msb; end
      3'd3: begin rn = (ri >> 1) | ((ri & 1) << (w - 1)); shn = ri & 1; end
      3'd4: begin rn = ((ri << 1) & mask) | msb; shn = msb; end
      3'd5: begin rn = (ri >> 1) | (msb << (w - 1)); shn = ri & 1; end
      3'd6: begin rn = l & mask; shn = 0; end
      3'd7: begin rn = 0; shn = 0; end
      default: ;
    endcase
    return {shn[0], rn[15:0]};
  endfunction

  function automatic int cur_w();
    return dsel ? 16 : 8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_direct(input logic [2:0] o, input logic d, input logic [15:0] l);
    op = o; din = d; ld = l; start = 1'b0;
    {m_sh, m_r} = ref_step(cur_w(), o, m_r, m_sh, d, l);
    tick();
  endtask

  task automatic test_reset();
    n_chk++;
    if ({out8, sh8, busy8, done8, out16, sh16, busy16, done16} !== 28'h0)
      $display("FAIL reset_init: got %h/%b%b%b %h/%b%b%b want all zero",
               out8, sh8, busy8, done8, out16, sh16, busy16, done16);
    else n_pass++;
  endtask

  task automatic test_direct();
    step_direct(3'd6, 1'b0, 16'h00A5);
    step_direct(3'd1, 1'b1, 16'h0);
    n_chk++;
    if ({out8, sh8} !== {8'hD2, 1'b1}) $display("FAIL direct_shr: got %h/%b want d2/1", out8, sh8);
    else n_pass++;
    step_direct(3'd2, 1'b0, 16'h0);
    n_chk++;
    if ({out8, sh8} !== {8'hA4, 1'b1}) $display("FAIL direct_shl: got %h/%b want a4/1", out8, sh8);
    else n_pass++;
    step_direct(3'd7, 1'b1, 16'h0);
    n_chk++;
    if ({out8, sh8, busy8, done8} !== 11'h0) $display("FAIL direct_clear: got %h/%b%b%b want 00/000", out8, sh8, busy8, done8);
    else n_pass++;
  endtask

  task automatic test_asr();
    step_direct(3'd6, 1'b0, 16'h0080);
    for (int i = 0; i < 3; i++) step_direct(3'd5, 1'b1, 16'h0);
    n_chk++;
    if ({out8, sh8} !== {8'hF0, 1'b0}) $display("FAIL asr3: got %h/%b want f0/0", out8, sh8);
    else n_pass++;
    step_direct(3'd0, 1'b1, 16'hFFFF);
    n_chk++;
    if ({out8, sh8} !== {8'hF0, 1'b0}) $display("FAIL asr_hold: got %h/%b want f0/0", out8, sh8);
    else n_pass++;
  endtask

  // Runs one burst on the selected instance; returns after sampling the done cycle.
  task automatic run_burst(input logic [2:0] bop, input int n, input int fixed_in, input string nm);
    int nbusy;
    logic d;
    op = bop; start = 1'b1; count = 5'(n); din = 1'($urandom);
    tick();
    n_chk++;
    if ({busy_s, done_s, out_s} !== {2'b10, m_r})
      $display("FAIL %s_accept: got busy=%b done=%b out=%h want 1/0/%h", nm, busy_s, done_s, out_s, m_r);
    else n_pass++;
    nbusy = 1;
    for (int j = 1; j <= n; j++) begin
      d = (fixed_in < 0) ? 1'($urandom) : 1'(fixed_in);
      din = d; op = 3'($urandom); ld = 16'($urandom); count = 5'($urandom); start = 1'($urandom);
      {m_sh, m_r} = ref_step(cur_w(), bop, m_r, m_sh, d, 16'h0);
      tick();
      if (busy_s) nbusy++;
      if (j < n && done_s !== 1'b0) begin
        n_chk++;
        $display("FAIL %s_early_done: got done=1 at step %0d of %0d", nm, j, n);
      end
    end
    n_chk++;
    if (nbusy !== n) $display("FAIL %s_busy_len: got %0d want %0d", nm, nbusy, n);
    else n_pass++;
    n_chk++;
    if ({out_s, sh_s, busy_s, done_s} !== {m_r, m_sh, 2'b01})
      $display("FAIL %s_done: got out=%h sh=%b busy=%b done=%b want %h/%b/0/1", nm, out_s, sh_s, busy_s, done_s, m_r, m_sh);
    else n_pass++;
    op = 3'd0; start = 1'b0; count = 5'd0;
  endtask

  task automatic check_done_drop(input string nm);
    tick();
    n_chk++;
    if ({busy_s, done_s, out_s} !== {2'b00, m_r})
      $display("FAIL %s_after: got busy=%b done=%b out=%h want 0/0/%h", nm, busy_s, done_s, out_s, m_r);
    else n_pass++;
  endtask

  task automatic test_burst_rol();
    step_direct(3'd6, 1'b0, 16'h0081);
    run_burst(3'd4, 4, -1, "rol4");
    n_chk++;
    if (out8 !== 8'h18) $display("FAIL rol4_value: got %h want 18", out8);
    else n_pass++;
    check_done_drop("rol4");
  endtask

  task automatic test_edge_starts();
    op = 3'd1; start = 1'b1; count = 5'd0; din = 1'b1;
    tick();
    n_chk++;
    if ({busy8, done8, out8} !== {2'b01, m_r[7:0]}) $display("FAIL cnt0: got busy=%b done=%b out=%h want 0/1/%h", busy8, done8, out8, m_r[7:0]);
    else n_pass++;
    start = 1'b0; op = 3'd0;
    check_done_drop("cnt0");
    op = 3'd6; start = 1'b1; count = 5'd3; ld = 16'h003C;
    {m_sh, m_r} = ref_step(8, 3'd6, m_r, m_sh, 1'b0, 16'h003C);
    tick();
    n_chk++;
    if ({busy8, done8, out8, sh8} !== {2'b00, 8'h3C, 1'b0}) $display("FAIL start_load: got busy=%b done=%b out=%h sh=%b want 0/0/3c/0", busy8, done8, out8, sh8);
    else n_pass++;
    start = 1'b0; op = 3'd0;
  endtask

  task automatic test_back_to_back();
    run_burst(3'd3, 3, -1, "b2b_first");
    run_burst(3'd2, 5, -1, "b2b_second");
    check_done_drop("b2b");
  endtask

  task automatic test_random();
    logic [2:0] o;
    int errs = 0;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      start = (o == 3'd0 || o >= 3'd6) ? 1'($urandom) : 1'b0;
      op = o; din = 1'($urandom); ld = 16'($urandom); count = 5'($urandom);
      {m_sh, m_r} = ref_step(8, o, m_r, m_sh, din, ld);
      tick();
      if ({out8, sh8, busy8, done8} !== {m_r[7:0], m_sh, 2'b00}) begin
        errs++;
        if (errs < 4) $display("FAIL rand_direct: op=%0d got %h/%b/%b%b want %h/%b/00", o, out8, sh8, busy8, done8, m_r[7:0], m_sh);
      end
    end
    start = 1'b0;
    n_chk++;
    if (errs != 0) $display("FAIL rand_direct_total: got %0d mismatching cycles want 0", errs);
    else n_pass++;
    for (int b = 0; b < 6; b++) begin
      run_burst(3'($urandom_range(1, 5)), $urandom_range(1, 15), -1, "rand_burst");
      check_done_drop("rand_burst");
    end
  endtask

  task automatic test_shr_fill();
    step_direct(3'd6, 1'b0, 16'h0012);
    run_burst(3'd1, 8, 1, "shr_fill");
    n_chk++;
    if (out8 !== 8'hFF) $display("FAIL shr_fill_value: got %h want ff", out8);
    else n_pass++;
    check_done_drop("shr_fill");
  endtask

  task automatic test_wrap();
    dsel = 1'b1;
    step_direct(3'd6, 1'b0, 16'h0001);
    run_burst(3'd3, 20, -1, "wrap16");
    n_chk++;
    if (out16 !== 16'h1000) $display("FAIL wrap16_value: got %h want 1000", out16);
    else n_pass++;
    check_done_drop("wrap16");
    dsel = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int bad = 0;
    m_r = {8'h0, out8}; m_sh = sh8;
    step_direct(3'd6, 1'b0, 16'h005A);
    op = 3'd1; start = 1'b1; count = 5'd10; din = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out8, sh8, busy8, done8, out16, sh16, busy16, done16} !== 28'h0)
      $display("FAIL reset_mid: got %h/%b%b%b %h/%b%b%b want all zero", out8, sh8, busy8, done8, out16, sh16, busy16, done16);
    else n_pass++;
    tick(); tick();
    #2 rst_n = 1'b1;
    op = 3'd0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 !== 1'b0 || busy8 !== 1'b0 || out8 !== 8'h00) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL reset_no_done: got %0d cycles with activity want 0", bad);
    else n_pass++;
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    test_direct();
    test_asr();
    test_burst_rol();
    test_edge_starts();
    test_back_to_back();
    test_random();
    test_shr_fill();
    test_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_univ.md
# shift_univ

Parametrised universal shift register: the next-generation replacement for the 8-bit left/right shifter. It adds configurable width, rotate, arithmetic shift, parallel load, clear, a registered shifted-out bit, and a burst mode that runs a shift or rotate for a programmed number of cycles with busy/done handshaking. It sits in datapaths as a serialiser, deserialiser or barrel-shift substitute, driven by a control FSM.

## Interface
- WIDTH, 8, register width (≥2)
- CNT_W, 4, width of the burst count input
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- op  in  3  operation: 0 HOLD, 1 SHR, 2 SHL, 3 ROR, 4 ROL, 5 ASR, 6 LOAD, 7 CLEAR
- in  in  1  serial input; enters the MSB on SHR and the LSB on SHL
- load_data  in  WIDTH  parallel load value for LOAD
- start  in  1  begins a burst when idle and op is 1..5
- count  in  CNT_W  number of burst steps (unsigned)
- out  out  WIDTH  register contents
- shout  out  1  bit shifted out by the most recent shift/rotate
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

## Operation
- Reset values: out=0, shout=0, busy=0, done=0, FSM=IDLE. Applies immediately on the reset edge and at any time, including mid-burst. A burst interrupted by reset produces no done pulse.
- Per-op update of the register r:
  - HOLD: r unchanged.
  - SHR: r = {in, r[W-1:1]}; shout = r[0].
  - SHL: r = {r[W-2:0], in}; shout = r[W-1].
  - ROR: r = {r[0], r[W-1:1]}; shout = r[0].
  - ROL: r = {r[W-2:0], r[W-1]}; shout = r[W-1].
  - ASR: r = {r[W-1], r[W-1:1]}; shout = r[0].
  - LOAD: r = load_data; shout = 0.
  - CLEAR: r = 0; shout = 0.
  - HOLD leaves shout unchanged.
- FSM states are IDLE and RUN.
- IDLE, start=0: op executes every cycle (direct mode).
- IDLE, start=1, op in 1..5, count>0:
  - Capture op and count; no shift on this edge.
  - Go to RUN; busy=1.
- IDLE, start=1, op in 1..5, count=0:
  - No shift and no busy.
  - done=1 for the next cycle.
- IDLE, start=1, op in {0,6,7}: start is ignored and op executes directly.
- RUN:
  - The captured op executes once per cycle. in is sampled live each cycle.
  - The op, start, load_data and count inputs are ignored.
  - A down-counter tracks the remaining steps.
  - After the final step, return to IDLE with busy=0 and done=1 for one cycle.
- count may exceed WIDTH:
  - Rotates wrap modulo WIDTH.
  - SHR/SHL fill the register with in.
  - ASR saturates to all-sign.
- done is never asserted in direct mode.

## Timing
- Direct mode: out and shout reflect op one edge after it is sampled. Zero added latency.
- Burst accepted at edge k (count=N>0):
  - busy=1 from edge k.
  - Shifts occur at edges k+1..k+N.
  - At edge k+N: busy→0 and done→1 together, with out holding the final value.
  - done→0 at edge k+N+1.
- A new start is accepted in the cycle done is high, since the FSM is already IDLE. Back-to-back bursts have a one-cycle gap with busy low.
- Count=0 start at edge k: done=1 from edge k to edge k+1.
- Reset deasserts asynchronously. The first op is sampled on the first rising edge with reset high.

## Test plan
- Reset: drive reset low mid-burst with out≠0 → out=0, shout=0, busy=0, done=0 immediately; no done pulse after release.
- Direct ops (WIDTH=8):
  - LOAD 0xA5, then SHR in=1 → out=0xD2, shout=1.
  - Then SHL in=0 → out=0xA4, shout=1.
  - Then CLEAR → out=0x00, shout=0.
- ASR: LOAD 0x80, then ASR for 3 cycles → out=0xF0, shout=0. HOLD keeps both unchanged.
- Burst ROL:
  - Stimulus: LOAD 0x81; start with op=ROL, count=4; toggle op and load_data during busy.
  - Response: busy high for exactly 4 cycles; out=0x18 as done pulses for one cycle; the toggled inputs have no effect.
- Edge starts:
  - start with count=0 → done for 1 cycle, busy stays 0, out unchanged.
  - start with op=LOAD → direct load, no busy or done.
  - Back-to-back bursts → one-cycle idle gap between them.
- Wrap (WIDTH=16, CNT_W=5): LOAD 0x0001, burst ROR with count=20 → out=0x1000 at done.
- SHR burst with in=1 and count=WIDTH → out=all ones.
